// File: rtl/sequencer_pkg.sv
// rtl/sequencer_pkg.sv - shared states, opcodes and PC helpers for the instruction sequencer
package sequencer_pkg;

    localparam int PC_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5
    } seq_state_t;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_BEQ   = 2'b11;

    // Two-bit branch immediate, sign-extended to the PC width (-2..+1).
    function automatic logic [PC_WIDTH-1:0] sext_offset(input logic [1:0] imm);
        return {{(PC_WIDTH-2){imm[1]}}, imm};
    endfunction

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - program counter with increment / branch-offset adder
// Advances by 1, or by 1 + sign-extended offset on a taken branch; wraps modulo 2^PC_WIDTH.
module program_counter
    import sequencer_pkg::*;
(
    input  logic                clock,
    input  logic                clear,
    input  logic                advance,
    input  logic                take_branch,
    input  logic [1:0]          offset,
    output logic [PC_WIDTH-1:0] pc
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    logic [PC_WIDTH-1:0] pc_step;

    always_comb begin
        pc_step = PC_ONE;
        if (take_branch) begin
            pc_step = PC_ONE + sext_offset(offset);
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            pc <= '0;
        end else if (advance) begin
            pc <= pc + pc_step;
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer
// Optional saturating performance counters are built when SEQ_PERF_COUNTERS_EN is defined.
module instruction_sequencer
    import sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic        step,
    input  logic [7:0]  instruction,
    input  logic        branch_taken,
    input  logic        mem_ack,
    output logic [7:0]  read_address,
    output logic [7:0]  current_instruction,
    output logic        ir_load,
    output logic        reg_read_en,
    output logic        alu_en,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_write_en,
    output logic [2:0]  state,
    output logic        busy,
    output logic        fault,
    output logic [15:0] retired_count,
    output logic [15:0] stall_count
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    seq_state_t state_q;
    seq_state_t state_d;
    logic [7:0] wait_cnt;
    logic [1:0] opcode;
    logic       retire;
    logic       take_branch;
    logic       fault_set;

    assign opcode = current_instruction[7:6];

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        take_branch = 1'b0;
        fault_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fault && (run || step)) begin
                    state_d = FETCH;
                end
            end
            FETCH:  state_d = DECODE;
            DECODE: state_d = EXECUTE;
            EXECUTE: begin
                case (opcode)
                    OP_ADD:            state_d = WRITEBACK;
                    OP_LOAD, OP_STORE: state_d = MEMORY;
                    default: begin
                        retire      = 1'b1;
                        take_branch = branch_taken;
                    end
                endcase
            end
            MEMORY: begin
                // Ack beats a timeout landing in the same cycle.
                if (mem_ack) begin
                    if (opcode == OP_STORE) begin
                        retire = 1'b1;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_d   = IDLE;
                    fault_set = 1'b1;
                end
            end
            WRITEBACK: retire = 1'b1;
            default:   state_d = IDLE;
        endcase
        if (retire) begin
            state_d = run ? FETCH : IDLE;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q             <= IDLE;
            current_instruction <= '0;
            fault               <= 1'b0;
            wait_cnt            <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH) begin
                current_instruction <= instruction;
            end
            if (fault_set) begin
                fault <= 1'b1;
            end
            wait_cnt <= (state_q == MEMORY && state_d == MEMORY) ? wait_cnt + 8'd1 : 8'd0;
        end
    end

    program_counter u_program_counter (
        .clock       (clock),
        .clear       (clear),
        .advance     (retire),
        .take_branch (take_branch),
        .offset      (current_instruction[1:0]),
        .pc          (read_address)
    );

    assign ir_load      = (state_q == FETCH);
    assign reg_read_en  = (state_q == DECODE);
    assign alu_en       = (state_q == EXECUTE);
    assign mem_req      = (state_q == MEMORY);
    assign mem_we       = (state_q == MEMORY) && (opcode == OP_STORE);
    assign reg_write_en = (state_q == WRITEBACK);
    assign state        = state_q;
    assign busy         = (state_q != IDLE);

`ifdef SEQ_PERF_COUNTERS_EN
    logic [15:0] retired_q;
    logic [15:0] stall_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (retire && retired_q != 16'hFFFF) begin
                retired_q <= retired_q + 16'd1;
            end
            if (state_q == MEMORY && !mem_ack && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign retired_count = retired_q;
    assign stall_count   = stall_q;
`else
    assign retired_count = '0;
    assign stall_count   = '0;
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - directed self-checking bench for instruction_sequencer
module tb_instruction_sequencer;

`ifdef SEQ_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  instruction = 8'h00;
    logic        branch_taken = 1'b0;
    logic        mem_ack = 1'b0;
    logic [7:0]  read_address;
    logic [7:0]  current_instruction;
    logic        ir_load;
    logic        reg_read_en;
    logic        alu_en;
    logic        mem_req;
    logic        mem_we;
    logic        reg_write_en;
    logic [2:0]  state;
    logic        busy;
    logic        fault;
    logic [15:0] retired_count;
    logic [15:0] stall_count;

    int tests = 0;
    int failed = 0;
    int hi_cycles;

    instruction_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clock               (clock),
        .clear               (clear),
        .run                 (run),
        .step                (step),
        .instruction         (instruction),
        .branch_taken        (branch_taken),
        .mem_ack             (mem_ack),
        .read_address        (read_address),
        .current_instruction (current_instruction),
        .ir_load             (ir_load),
        .reg_read_en         (reg_read_en),
        .alu_en              (alu_en),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .reg_write_en        (reg_write_en),
        .state               (state),
        .busy                (busy),
        .fault               (fault),
        .retired_count       (retired_count),
        .stall_count         (stall_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic run_adds(input int n, input logic [7:0] pc_start);
        instruction = 8'h00;
        run = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            tick();
            tick();
            tick();
            if (i == n - 1) run = 1'b0;
            tick();
            if (i == 0 && n > 1) begin
                check("b2b_fetch_state", 16'(state), 16'd1);
                check("b2b_pc", 16'(read_address), 16'(pc_start + 8'd1));
            end
        end
    endtask

    task automatic run_beq(input logic [1:0] imm, input logic taken, input logic [7:0] exp_pc);
        instruction = {2'b11, 4'b0000, imm};
        branch_taken = taken;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        check("beq_alu_en", 16'(alu_en), 16'd1);
        tick();
        check("beq_idle", 16'(state), 16'd0);
        check("beq_pc", 16'(read_address), 16'(exp_pc));
        branch_taken = 1'b0;
    endtask

    initial begin
        // Reset values
        tick();
        check("rst_state", 16'(state), 16'd0);
        check("rst_pc", 16'(read_address), 16'd0);
        check("rst_ir", 16'(current_instruction), 16'd0);
        check("rst_strobes", 16'({ir_load, reg_read_en, alu_en, mem_req, mem_we, reg_write_en}), 16'd0);
        check("rst_busy_fault", 16'({busy, fault}), 16'd0);
        check("rst_counters", retired_count | stall_count, 16'd0);
        clear = 1'b0;

        // ADD free-run, single instruction
        instruction = 8'b00_01_10_11;
        run = 1'b1;
        tick();
        check("add_fetch", 16'(state), 16'd1);
        check("add_ir_load", 16'(ir_load), 16'd1);
        tick();
        check("add_decode", 16'(state), 16'd2);
        check("add_reg_read", 16'(reg_read_en), 16'd1);
        tick();
        check("add_execute", 16'(state), 16'd3);
        check("add_ir_value", 16'(current_instruction), 16'h1B);
        tick();
        check("add_writeback", 16'(state), 16'd5);
        check("add_wb_strobe", 16'(reg_write_en), 16'd1);
        check("add_pc_before", 16'(read_address), 16'd0);
        run = 1'b0;
        tick();
        check("add_idle", 16'(state), 16'd0);
        check("add_wb_low", 16'(reg_write_en), 16'd0);
        check("add_pc_after", 16'(read_address), 16'd1);

        // Four back-to-back ADDs: PC 1 -> 5
        run_adds(4, 8'd1);
        check("adds_pc5", 16'(read_address), 16'd5);

        // BEQ offsets: taken -2, then not taken twice
        run_beq(2'b10, 1'b1, 8'd4);
        run_beq(2'b10, 1'b0, 8'd5);
        run_beq(2'b10, 1'b0, 8'd6);

        // LOAD, ack in the 4th MEMORY cycle; early ack in EXECUTE is ignored
        instruction = 8'b01_000000;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        mem_ack = 1'b1;
        tick();
        check("load_mem_entry", 16'(state), 16'd4);
        mem_ack = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check("load_mem_req", 16'({mem_req, mem_we}), 16'b10);
            if (c == 4) mem_ack = 1'b1;
            tick();
        end
        check("load_writeback", 16'(state), 16'd5);
        check("load_req_low", 16'(mem_req), 16'd0);
        mem_ack = 1'b0;
        check("load_stalls", stall_count, PERF ? 16'd3 : 16'd0);
        tick();
        check("load_pc", 16'(read_address), 16'd7);

        // STORE timeout
        instruction = 8'b10_000000;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        tick();
        hi_cycles = 0;
        for (int c = 0; c < 15; c++) begin
            if (mem_req && mem_we) hi_cycles++;
            tick();
        end
        check("store_req_cycles", 16'(hi_cycles), 16'd15);
        check("store_timeout_idle", 16'(state), 16'd0);
        check("store_fault", 16'(fault), 16'd1);
        check("store_pc_kept", 16'(read_address), 16'd7);
        run = 1'b1;
        tick();
        tick();
        check("fault_run_stuck", 16'({busy, state}), 16'd0);
        run = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        check("fault_step_stuck", 16'({busy, state}), 16'd0);

        // Clear releases the fault; BEQ wrap at PC 0
        clear = 1'b1;
        #1;
        check("clear_fault", 16'({fault, read_address}), 16'd0);
        tick();
        clear = 1'b0;
        run_beq(2'b10, 1'b1, 8'hFF);
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // Single-step with a stray step during EXECUTE
        instruction = 8'h00;
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_fetch", 16'(state), 16'd1);
        tick();
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_writeback", 16'(state), 16'd5);
        tick();
        check("step_idle", 16'({busy, state}), 16'd0);
        check("step_pc", 16'(read_address), 16'd1);
        tick();
        check("step_stays_idle", 16'(state), 16'd0);

        // Async clear in MEMORY
        clear = 1'b1;
        tick();
        clear = 1'b0;
        run_adds(3, 8'd0);
        check("retired_3", retired_count, PERF ? 16'd3 : 16'd0);
        instruction = 8'b01_000000;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        tick();
        check("mid_mem_req", 16'(mem_req), 16'd1);
        #2 clear = 1'b1;
        #1;
        check("async_req_drop", 16'(mem_req), 16'd0);
        check("async_state", 16'(state), 16'd0);
        check("async_pc", 16'(read_address), 16'd0);
        check("async_retired", retired_count, 16'd0);
        tick();
        clear = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Multi-cycle sequencer for the 8-bit microprocessor datapath. It owns the program counter (`read_address`) and the instruction register, and steps each instruction through IDLE/FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. Each state raises one enable strobe to the register file, ALU and data memory. It sits between the divided `clock` domain, the instruction source and the datapath, and supports free-run, single-step and a memory-handshake timeout.

## Interface
- `MEM_TIMEOUT`, default 15: maximum MEMORY cycles without `mem_ack` before abort (1..255).
- `clock` in 1: single clock, rising edge.
- `clear` in 1: reset, asynchronous, active-high.
- `run` in 1: level; free-run when high.
- `step` in 1: one-cycle pulse; executes one instruction when `run`=0.
- `instruction` in 8: instruction word at `read_address`; `[7:6]` opcode, `[1:0]` branch immediate.
- `branch_taken` in 1: datapath compare result, valid in EXECUTE.
- `mem_ack` in 1: data-memory completion, sampled in MEMORY.
- `read_address` out 8: program counter.
- `current_instruction` out 8: instruction register.
- `ir_load`, `reg_read_en`, `alu_en`, `mem_req`, `mem_we`, `reg_write_en` out 1 each: state strobes.
- `state` out 3: encoded FSM state.
- `busy` out 1: high when `state` is not IDLE.
- `fault` out 1: sticky memory-timeout flag.
- `retired_count` out 16: performance counter; see Configuration.
- `stall_count` out 16: performance counter; see Configuration.

## Operation
- Opcodes: 00 ADD, 01 LOAD, 10 STORE, 11 BEQ.
- Paths:
  - ADD: FETCH→DECODE→EXECUTE→WRITEBACK.
  - LOAD: FETCH→DECODE→EXECUTE→MEMORY→WRITEBACK.
  - STORE: FETCH→DECODE→EXECUTE→MEMORY, retire on ack.
  - BEQ: FETCH→DECODE→EXECUTE, retire.
- IDLE→FETCH when `run`=1, or when a `step` pulse arrives with `run`=0. `step` is ignored outside IDLE and ignored while `run`=1. IDLE is never left while `fault`=1.
- The instruction register loads `instruction` on the edge leaving FETCH.
- Strobes are Moore outputs, decoded only from the registered state:
  - `ir_load`: FETCH.
  - `reg_read_en`: DECODE.
  - `alu_en`: EXECUTE.
  - `mem_req`: MEMORY.
  - `mem_we`: MEMORY with STORE.
  - `reg_write_en`: WRITEBACK.
- Retire: on the retiring edge, PC ← PC+1. For BEQ with `branch_taken`=1, PC ← PC+1+sext(`[1:0]`) instead; the offset range is −2..+1. All PC arithmetic is 8-bit modulo 256, wrap silent.
- After retire: next state FETCH if `run`=1, else IDLE.
- MEMORY: stay until `mem_ack`=1. Ack in the first MEMORY cycle means zero wait.
  - The wait counter counts MEMORY cycles.
  - If MEM_TIMEOUT cycles pass without ack: go to IDLE, set `fault`, PC unchanged, instruction not retired.
- `mem_ack` outside MEMORY is ignored.
- Simultaneous ack and timeout in the same cycle: ack wins.

## Timing
- Reset values: `read_address` 0, `current_instruction` 0, `state` IDLE, all strobes 0, `busy` 0, `fault` 0, counters 0.
- `clear` asynchronously forces reset values mid-instruction; `mem_req` drops without waiting for the clock.
- Latency from IDLE start:
  - ADD: 4 cycles.
  - LOAD: 5+w cycles, where w is the number of ack wait cycles.
  - STORE: 4+w cycles.
  - BEQ: 3 cycles.
- Back-to-back with `run`=1: FETCH follows retire directly, no IDLE cycle.
- `read_address` changes only on retiring edges and on `clear`.

## Configuration
- `SEQ_PERF_COUNTERS_EN` defined:
  - `retired_count` increments on every retiring edge.
  - `stall_count` increments on every MEMORY cycle with `mem_ack`=0.
  - Both counters saturate at 16'hFFFF and are cleared by `clear`.
- Undefined: both ports remain and are driven constant 0; no counter flops are synthesized.

## Structure
- Shared package `sequencer_pkg`:
  - state enum: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5.
  - opcode constants: OP_ADD, OP_LOAD, OP_STORE, OP_BEQ.
  - PC width constant 8.
- Sub-module `program_counter`: holds the PC register, increment/branch-offset adder and async clear. The FSM drives its `advance`, `take_branch` and `offset` inputs.

## Test plan
- ADD, free-run: clear, `run`=1, `instruction`=8'b00_01_10_11 → states 0,1,2,3,5, `reg_write_en` high exactly one cycle, `read_address` 0→1 on the edge leaving WRITEBACK.
- BEQ at PC=5, imm=2'b10: `branch_taken`=1 → PC=4; `branch_taken`=0 → PC=6. BEQ at PC=0, imm=2'b10, taken → PC=8'hFF (wrap).
- LOAD with ack delay: ack in the 4th MEMORY cycle → `mem_req` high 4 cycles, `mem_we`=0, then WRITEBACK. With the macro defined, `stall_count`=3.
- STORE timeout: no ack, MEM_TIMEOUT=15 → `mem_req` and `mem_we` high 15 cycles, then IDLE with `fault`=1 and PC unchanged. A subsequent `run`/`step` stays in IDLE until `clear`.
- Single-step: `run`=0, one `step` pulse → exactly one ADD retires, then IDLE with `busy`=0. A `step` pulse during EXECUTE is ignored.
- Reset mid-operation: `clear` asserted mid-cycle in MEMORY → `mem_req` falls before the next edge, PC=0, state IDLE. With the macro defined, 3 ADDs retired before clear give `retired_count`=3, and `retired_count`=0 after clear.
